// File: rtl/m65c02_bcd_pkg.sv
// Shared constants, state encoding and input validation helper for the
// M65C02 binary/packed-BCD converter.
package m65c02_bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } bcd_state_e;

   localparam int         ITER_CNT   = 8;
   localparam logic       OP_BIN2BCD = 1'b0;
   localparam logic       OP_BCD2BIN = 1'b1;
   localparam logic [3:0] ADJ_ADD_TH = 4'd5;
   localparam logic [3:0] ADJ_SUB_TH = 4'd8;

   // True when either packed-BCD digit is outside 0..9.
   function automatic logic nibble_invalid(input logic [7:0] d);
      return (d[7:4] > 4'd9) || (d[3:0] > 4'd9);
   endfunction

endpackage

// File: rtl/m65c02_bcd_digit_adj.sv
// Combinational per-digit conditional adjust: dir=0 adds 3 to digits >= 5,
// dir=1 subtracts 3 from digits >= 8. Arithmetic wraps within the nibble.
module m65c02_bcd_digit_adj
   import m65c02_bcd_pkg::*;
(
   input  logic       dir_i,
   input  logic [3:0] dig_i,
   output logic [3:0] dig_o
);

   always_comb begin
      dig_o = dig_i;
      if (dir_i == OP_BIN2BCD) begin
         if (dig_i >= ADJ_ADD_TH) dig_o = dig_i + 4'd3;
      end else begin
         if (dig_i >= ADJ_SUB_TH) dig_o = dig_i - 4'd3;
      end
   end

endmodule

// File: rtl/m65c02_bcd_cvt.sv
// Multi-cycle binary <-> packed-BCD converter (double dabble / reverse).
// Define BCD_CVT_ERRCHK_EN to compile in the invalid-BCD check and Err fast path.
module m65c02_bcd_cvt
   import m65c02_bcd_pkg::*;
(
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Start,
   input  logic        Op,
   input  logic [7:0]  Din,
   output logic        Busy,
   output logic [11:0] Out,
   output logic        Err,
   output logic        Val,
   output logic [1:0]  dbg_state_o
);

   bcd_state_e  state_q, state_d;
   logic        op_q, op_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [19:0] sr_q, sr_d;
   logic [11:0] out_q, out_d;
   logic        err_q, err_d;
   logic        val_q, val_d;
   logic        errf_q, errf_d;

   logic        bad_start;
   logic [15:0] shr16;
   logic [11:0] adj_in;
   logic [11:0] adj_out;
   logic [19:0] iter_next;
   logic [11:0] result;

`ifdef BCD_CVT_ERRCHK_EN
   assign bad_start = (Op == OP_BCD2BIN) && nibble_invalid(Din);
`else
   assign bad_start = 1'b0;
`endif

   // BCD->binary works on the low 16 bits: shift first, then adjust digits.
   assign shr16  = {1'b0, sr_q[15:1]};
   assign adj_in = (op_q == OP_BIN2BCD) ? sr_q[19:8] : {4'b0000, shr16[15:8]};

   for (genvar g = 0; g < 3; g++) begin : g_adj
      m65c02_bcd_digit_adj u_adj (
         .dir_i (op_q),
         .dig_i (adj_in[4*g +: 4]),
         .dig_o (adj_out[4*g +: 4])
      );
   end

   assign iter_next = (op_q == OP_BIN2BCD) ? {adj_out[10:0], sr_q[7:0], 1'b0}
                                           : {4'b0000, adj_out[7:0], shr16[7:0]};
   assign result    = (op_q == OP_BIN2BCD) ? sr_q[19:8] : {5'b00000, sr_q[6:0]};

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      out_d   = out_q;
      err_d   = err_q;
      errf_d  = errf_q;
      val_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (Start) begin
               op_d    = Op;
               cnt_d   = 3'd0;
               errf_d  = bad_start;
               sr_d    = (Op == OP_BIN2BCD) ? {12'h000, Din} : {4'h0, Din, 8'h00};
               state_d = bad_start ? ST_DONE : ST_CONV;
            end
         end
         ST_CONV: begin
            sr_d  = iter_next;
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'(ITER_CNT - 1)) state_d = ST_DONE;
         end
         ST_DONE: begin
            out_d   = errf_q ? 12'h000 : result;
            err_d   = errf_q;
            val_d   = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Registers update on the falling edge, like the other ALU units.
   always_ff @(negedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= ST_IDLE;
         op_q    <= OP_BIN2BCD;
         cnt_q   <= 3'd0;
         sr_q    <= 20'h00000;
         out_q   <= 12'h000;
         err_q   <= 1'b0;
         errf_q  <= 1'b0;
         val_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
         out_q   <= out_d;
         err_q   <= err_d;
         errf_q  <= errf_d;
         val_q   <= val_d;
      end
   end

   assign Busy        = (state_q != ST_IDLE);
   assign Out         = out_q;
   assign Err         = err_q;
   assign Val         = val_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_m65c02_bcd_cvt.sv
// Self-checking bench for m65c02_bcd_cvt: directed cases, exhaustive
// round-trip and randomized conversions against an arithmetic reference.
module tb_m65c02_bcd_cvt;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic        Start = 1'b0;
   logic        Op = 1'b0;
   logic [7:0]  Din = 8'h00;
   logic        Busy;
   logic [11:0] Out;
   logic        Err;
   logic        Val;
   logic [1:0]  dbg_state;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [11:0] exp_q[$];

   m65c02_bcd_cvt dut (
      .Clk         (Clk),
      .Rst         (Rst),
      .Start       (Start),
      .Op          (Op),
      .Din         (Din),
      .Busy        (Busy),
      .Out         (Out),
      .Err         (Err),
      .Val         (Val),
      .dbg_state_o (dbg_state)
   );

   always #5 Clk = ~Clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] ref_bin2bcd(input int b);
      return {4'(b / 100), 4'((b / 10) % 10), 4'(b % 10)};
   endfunction

   function automatic logic [11:0] ref_bcd2bin(input logic [7:0] d);
      return 12'(int'(d[7:4]) * 10 + int'(d[3:0]));
   endfunction

   // Start one conversion and check result, error, latency, busy length and strobe width.
   task automatic conv_check(input string tag, input logic op, input logic [7:0] din,
                             input logic [11:0] exp_out, input logic exp_err,
                             input int exp_edges, input int exp_busy);
      int          edges;
      int          bcyc;
      logic [11:0] exp;
      exp_q.push_back(exp_out);
      @(posedge Clk);
      Start = 1'b1; Op = op; Din = din;
      @(posedge Clk);
      Start = 1'b0;
      edges = 1;
      bcyc  = 0;
      while (!Val && edges < 40) begin
         if (Busy) bcyc++;
         @(posedge Clk);
         edges++;
      end
      exp = exp_q.pop_front();
      check_val({tag, "_val_seen"}, Val, 1'b1);
      check_val({tag, "_out"}, Out, exp);
      check_val({tag, "_err"}, Err, exp_err);
      check_val({tag, "_latency"}, edges, exp_edges);
      check_val({tag, "_busy_cycles"}, bcyc, exp_busy);
      check_val({tag, "_busy_at_val"}, Busy, 1'b0);
      @(posedge Clk);
      check_val({tag, "_val_one_cycle"}, Val, 1'b0);
      check_val({tag, "_out_hold"}, Out, exp);
   endtask

   initial begin
      int          vals;
      int          bcyc;
      int          t;
      logic [11:0] bcd;
      logic        op;
      logic [7:0]  din;

      #1 Rst = 1'b1;
      @(posedge Clk);
      check_val("rst_busy", Busy, 1'b0);
      check_val("rst_val", Val, 1'b0);
      check_val("rst_err", Err, 1'b0);
      check_val("rst_out", Out, 12'h000);
      check_val("rst_state", dbg_state, 2'd0);
      @(posedge Clk);
      Rst = 1'b0;

      conv_check("b2d_ff", 1'b0, 8'hFF, 12'h255, 1'b0, 10, 9);
      conv_check("d2b_99", 1'b1, 8'h99, 12'h063, 1'b0, 10, 9);
      conv_check("d2b_00", 1'b1, 8'h00, 12'h000, 1'b0, 10, 9);
`ifdef BCD_CVT_ERRCHK_EN
      conv_check("d2b_bad", 1'b1, 8'h9A, 12'h000, 1'b1, 2, 1);
      conv_check("after_bad", 1'b1, 8'h42, 12'h02A, 1'b0, 10, 9);
`endif

      // Start held through the whole conversion: one strobe, restart only at N+10.
      @(posedge Clk);
      Start = 1'b1; Op = 1'b0; Din = 8'hFF;
      vals = 0;
      bcyc = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge Clk);
         if (Val) vals++;
         if (Busy) bcyc++;
      end
      check_val("hold_val_at_n9", Val, 1'b1);
      check_val("hold_busy_at_n9", Busy, 1'b0);
      check_val("hold_busy_cycles", bcyc, 9);
      check_val("hold_single_val", vals, 1);
      @(posedge Clk);
      check_val("hold_restart_n10", Busy, 1'b1);
      Start = 1'b0;
      t = 0;
      while (!Val && t < 40) begin
         @(posedge Clk);
         t++;
      end
      check_val("hold_second_val", Val, 1'b1);
      check_val("hold_second_out", Out, 12'h255);
      @(posedge Clk);

      // Reset in mid-flight after the fourth iteration.
      conv_check("pre_rst", 1'b0, 8'hFF, 12'h255, 1'b0, 10, 9);
      @(posedge Clk);
      Start = 1'b1; Op = 1'b0; Din = 8'h80;
      @(posedge Clk);
      Start = 1'b0;
      repeat (4) @(posedge Clk);
      Rst = 1'b1;
      #1;
      check_val("midrst_busy", Busy, 1'b0);
      check_val("midrst_val", Val, 1'b0);
      check_val("midrst_err", Err, 1'b0);
      check_val("midrst_out", Out, 12'h000);
      check_val("midrst_state", dbg_state, 2'd0);
      @(posedge Clk);
      Rst = 1'b0;
      conv_check("post_rst_80", 1'b0, 8'h80, 12'h128, 1'b0, 10, 9);

      // Exhaustive binary->BCD, with BCD->binary round trip for 0..99.
      for (int b = 0; b < 256; b++) begin
         bcd = ref_bin2bcd(b);
         conv_check("exh_b2d", 1'b0, 8'(b), bcd, 1'b0, 10, 9);
         if (b < 100)
            conv_check("exh_rt", 1'b1, bcd[7:0], 12'(b), 1'b0, 10, 9);
      end

      // Randomized mix of both directions.
      for (int i = 0; i < 120; i++) begin
         op = 1'($urandom_range(0, 1));
         if (op == 1'b0) begin
            din = 8'($urandom_range(0, 255));
            conv_check("rnd_b2d", 1'b0, din, ref_bin2bcd(int'(din)), 1'b0, 10, 9);
         end else begin
            din = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            conv_check("rnd_d2b", 1'b1, din, ref_bcd2bin(din), 1'b0, 10, 9);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
      $fatal(1, "watchdog");
   end

endmodule
